// File: rtl/conv_window_scheduler_if.sv
// Request/response/write-back bundle between the convolution scheduler, the shared
// MAC engine and the layer output buffer.
interface conv_window_scheduler_if #(
   parameter int DATA_WIDTH = 16,
   parameter int H          = 32,
   parameter int W          = 32,
   parameter int F          = 5,
   parameter int K          = 6,
   parameter int P          = 2
);
   localparam int OH    = H - F + 1 + 2 * P;
   localparam int OW    = W - F + 1 + 2 * P;
   localparam int TOTAL = K * OH * OW;
   localparam int AW    = $clog2(TOTAL);
   localparam int FW    = $clog2(K);
   localparam int RW    = $clog2(H + P) + 1;
   localparam int CW    = $clog2(W + P) + 1;

   logic                         req_valid;
   logic                         req_ready;
   logic        [FW-1:0]         req_filter;
   logic signed [RW-1:0]         req_row;
   logic signed [CW-1:0]         req_col;
   logic                         rsp_valid;
   logic        [DATA_WIDTH-1:0] rsp_data;
   logic                         wr_en;
   logic        [AW-1:0]         wr_addr;
   logic        [DATA_WIDTH-1:0] wr_data;

   modport master (
      output req_valid, req_filter, req_row, req_col, wr_en, wr_addr, wr_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_filter, req_row, req_col, wr_en, wr_addr, wr_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/conv_window_scheduler.sv
// Walks every filter and output pixel of a padded convolution, issues one window
// request per pixel to the MAC engine under a credit limit, and writes results back in order.
module conv_window_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int H          = 32,
   parameter int W          = 32,
   parameter int F          = 5,
   parameter int K          = 6,
   parameter int P          = 2,
   parameter int MAX_OUT    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   conv_window_scheduler_if.master bus
);
   localparam int OH    = H - F + 1 + 2 * P;
   localparam int OW    = W - F + 1 + 2 * P;
   localparam int TOTAL = K * OH * OW;
   localparam int AW    = $clog2(TOTAL);
   localparam int FW    = $clog2(K);
   localparam int RW    = $clog2(H + P) + 1;
   localparam int CW    = $clog2(W + P) + 1;
   localparam int RCW   = $clog2(OH);
   localparam int CCW   = $clog2(OW);
   localparam int OCW   = $clog2(MAX_OUT + 1);

   localparam logic [FW-1:0]  FILTER_LAST = FW'(K - 1);
   localparam logic [RCW-1:0] ROW_LAST    = RCW'(OH - 1);
   localparam logic [CCW-1:0] COL_LAST    = CCW'(OW - 1);
   localparam logic [AW-1:0]  ADDR_LAST   = AW'(TOTAL - 1);
   localparam logic [OCW-1:0] CREDIT_MAX  = OCW'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                  state;
   logic [FW-1:0]           filter_cnt;
   logic [RCW-1:0]          row_cnt;
   logic [CCW-1:0]          col_cnt;
   logic [OCW-1:0]          outstanding;
   logic [AW-1:0]           wr_cnt;
   logic                    wr_en_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;

   logic fire;
   logic rsp_ok;
   logic spurious;
   logic last_req;
   logic last_wr;

   // Credit is judged on the registered count only, so a response in this cycle
   // frees a slot no earlier than the next one.
   assign bus.req_valid  = (state == ISSUE) && (outstanding < CREDIT_MAX);
   assign bus.req_filter = filter_cnt;
   assign bus.req_row    = RW'(row_cnt) - RW'(P);
   assign bus.req_col    = CW'(col_cnt) - CW'(P);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_cnt;
   assign bus.wr_data    = wr_data_q;

   assign fire     = bus.req_valid && bus.req_ready;
   assign rsp_ok   = bus.rsp_valid && (outstanding != '0);
   assign spurious = bus.rsp_valid && (outstanding == '0);
   assign last_req = (filter_cnt == FILTER_LAST) && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
   assign last_wr  = wr_en_q && (wr_cnt == ADDR_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         filter_cnt  <= '0;
         row_cnt     <= '0;
         col_cnt     <= '0;
         outstanding <= '0;
         wr_cnt      <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
      end else begin
         done    <= 1'b0;
         wr_en_q <= rsp_ok;
         if (rsp_ok) begin
            wr_data_q <= bus.rsp_data;
         end
         if (spurious) begin
            err <= 1'b1;
         end
         if (wr_en_q) begin
            wr_cnt <= last_wr ? '0 : wr_cnt + AW'(1);
         end

         if (fire && !rsp_ok) begin
            outstanding <= outstanding + OCW'(1);
         end else if (!fire && rsp_ok) begin
            outstanding <= outstanding - OCW'(1);
         end

         // Column is innermost, filter outermost; everything wraps back to zero after the last window.
         if (fire) begin
            if (col_cnt == COL_LAST) begin
               col_cnt <= '0;
               if (row_cnt == ROW_LAST) begin
                  row_cnt    <= '0;
                  filter_cnt <= (filter_cnt == FILTER_LAST) ? '0 : filter_cnt + FW'(1);
               end else begin
                  row_cnt <= row_cnt + RCW'(1);
               end
            end else begin
               col_cnt <= col_cnt + CCW'(1);
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= ISSUE;
                  busy        <= 1'b1;
                  filter_cnt  <= '0;
                  row_cnt     <= '0;
                  col_cnt     <= '0;
                  outstanding <= '0;
                  wr_cnt      <= '0;
               end
            end
            ISSUE: begin
               if (fire && last_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_wr) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench: an in-order MAC engine model feeds a scoreboard of expected
// output-buffer writes, while a reference walk checks every issued window.
module tb_conv_window_scheduler;
   localparam int DATA_WIDTH = 16;
   localparam int H          = 32;
   localparam int W          = 32;
   localparam int F          = 5;
   localparam int K          = 6;
   localparam int P          = 2;
   localparam int MAX_OUT    = 4;
   localparam int OH         = H - F + 1 + 2 * P;
   localparam int OW         = W - F + 1 + 2 * P;
   localparam int TOTAL      = K * OH * OW;
   localparam int LAT        = 2;
   localparam int BOUND      = 2 * TOTAL + 200;

   logic clk;
   logic reset;
   logic start;
   logic busy;
   logic done;
   logic err;

   conv_window_scheduler_if #(
      .DATA_WIDTH(DATA_WIDTH), .H(H), .W(W), .F(F), .K(K), .P(P)
   ) bus ();

   conv_window_scheduler #(
      .DATA_WIDTH(DATA_WIDTH), .H(H), .W(W), .F(F), .K(K), .P(P), .MAX_OUT(MAX_OUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int m_k, m_r, m_c, m_out, m_wr, fires, edge_no;
   bit m_busy, m_issuing, m_err, done_next, m_in_done, layer_done_seen;
   bit start_req, hold_rsp, force_spur, bp_enable;
   int rsp_budget, bp_cnt;
   int exp_addr_q[$];
   int exp_data_q[$];
   int due_q[$];
   int rsp_q[$];

   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clearModel();
      m_k = 0; m_r = 0; m_c = 0; m_out = 0; m_wr = 0; fires = 0;
      m_busy = 0; m_issuing = 0; done_next = 0; m_in_done = 0;
      exp_addr_q.delete(); exp_data_q.delete(); due_q.delete(); rsp_q.delete();
   endtask

   // One clock: check what the last edge produced, then drive and model the next edge.
   task automatic applyStimulus();
      bit exp_done;
      bit fire;
      int data;
      @(posedge clk);
      #1;
      edge_no++;
      exp_done  = done_next;
      done_next = 0;
      m_in_done = exp_done;
      if (exp_done) begin
         m_busy          = 0;
         layer_done_seen = 1;
      end
      checkOutput("done", done, exp_done);
      checkOutput("busy", busy, m_busy);
      checkOutput("err", err, m_err);
      checkOutput("req_valid", bus.req_valid, (m_issuing && m_out < MAX_OUT));
      if (bus.req_valid) begin
         checkOutput("req_filter", bus.req_filter, m_k);
         checkOutput("req_row", bus.req_row, m_r - P);
         checkOutput("req_col", bus.req_col, m_c - P);
      end
      if (bus.wr_en) begin
         if (exp_addr_q.size() == 0) begin
            checkOutput("unexpected_write", 1, 0);
         end else begin
            checkOutput("wr_addr", bus.wr_addr, exp_addr_q.pop_front());
            checkOutput("wr_data", bus.wr_data, exp_data_q.pop_front());
            m_wr++;
            if (m_wr == TOTAL) done_next = 1;
         end
      end

      start     = start_req;
      start_req = 0;
      bus.req_ready = 1'b1;
      if (bp_enable && fires == 33 && bp_cnt < 5) begin
         bus.req_ready = 1'b0;
         bp_cnt++;
         checkOutput("bp_valid", bus.req_valid, 1);
         checkOutput("bp_filter", bus.req_filter, 0);
         checkOutput("bp_row", bus.req_row, -1);
         checkOutput("bp_col", bus.req_col, -1);
      end
      bus.rsp_valid = 1'b0;
      if (force_spur) begin
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = 16'($urandom_range(0, 65535));
         force_spur    = 0;
      end else if (due_q.size() > 0 && due_q[0] <= edge_no + 1 && (!hold_rsp || rsp_budget > 0)) begin
         void'(due_q.pop_front());
         bus.rsp_data  = 16'(rsp_q.pop_front());
         bus.rsp_valid = 1'b1;
         if (hold_rsp) rsp_budget--;
      end

      if (start && !m_busy && !m_in_done) begin
         clearModel();
         m_busy    = 1;
         m_issuing = 1;
      end
      if (bus.rsp_valid) begin
         if (m_out == 0) m_err = 1;
         else m_out--;
      end
      fire = bus.req_valid && bus.req_ready;
      if (fire) begin
         if (fires == 0) begin
            checkOutput("first_filter", bus.req_filter, 0);
            checkOutput("first_row", bus.req_row, -2);
            checkOutput("first_col", bus.req_col, -2);
         end
         if (fires == 32) begin
            checkOutput("req32_filter", bus.req_filter, 0);
            checkOutput("req32_row", bus.req_row, -1);
            checkOutput("req32_col", bus.req_col, -2);
         end
         if (fires == TOTAL - 1) begin
            checkOutput("last_filter", bus.req_filter, 5);
            checkOutput("last_row", bus.req_row, 29);
            checkOutput("last_col", bus.req_col, 29);
         end
         data = int'($urandom_range(0, 65535));
         exp_addr_q.push_back(m_k * OH * OW + m_r * OW + m_c);
         exp_data_q.push_back(data);
         due_q.push_back(edge_no + 1 + LAT);
         rsp_q.push_back(data);
         m_out++;
         fires++;
         if (m_c == OW - 1) begin
            m_c = 0;
            if (m_r == OH - 1) begin
               m_r = 0;
               if (m_k == K - 1) begin
                  m_k       = 0;
                  m_issuing = 0;
               end else begin
                  m_k++;
               end
            end else begin
               m_r++;
            end
         end else begin
            m_c++;
         end
      end
   endtask

   task automatic doReset();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_req_valid", bus.req_valid, 0);
      checkOutput("rst_wr_en", bus.wr_en, 0);
      checkOutput("rst_req_filter", bus.req_filter, 0);
      checkOutput("rst_wr_addr", bus.wr_addr, 0);
      checkOutput("rst_wr_data", bus.wr_data, 0);
      checkOutput("rst_req_row", bus.req_row, -2);
      checkOutput("rst_req_col", bus.req_col, -2);
      clearModel();
      m_err         = 0;
      start         = 1'b0;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic pulseStart();
      start_req       = 1;
      layer_done_seen = 0;
      bp_cnt          = 0;
      applyStimulus();
   endtask

   task automatic runSteps(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic runLayer();
      int n = 0;
      while (!layer_done_seen && n < BOUND) begin
         applyStimulus();
         n++;
      end
      checkOutput("layer_complete", layer_done_seen, 1);
      checkOutput("write_count", m_wr, TOTAL);
      checkOutput("scoreboard_empty", exp_addr_q.size(), 0);
   endtask

   task automatic runFires(input int target);
      int n = 0;
      while (fires < target && n < BOUND) begin
         applyStimulus();
         n++;
      end
      checkOutput("reach_fires", (fires >= target), 1);
   endtask

   initial begin
      reset         = 1'b0;
      start         = 1'b0;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      edge_no = 0; m_err = 0; start_req = 0; hold_rsp = 0; force_spur = 0;
      bp_enable = 0; rsp_budget = 0; bp_cnt = 0; layer_done_seen = 0;
      clearModel();
      repeat (2) @(posedge clk);
      doReset();

      $display("[TB] full layer with backpressure at request 33");
      bp_enable = 1;
      pulseStart();
      runLayer();
      checkOutput("bp_cycles", bp_cnt, 5);
      bp_enable = 0;

      $display("[TB] credit limit and ignored start");
      hold_rsp = 1;
      pulseStart();
      runSteps(10);
      checkOutput("credit_fires", fires, 4);
      checkOutput("credit_stall", bus.req_valid, 0);
      start_req = 1;
      runSteps(3);
      rsp_budget = 1;
      runSteps(5);
      checkOutput("one_rsp_fires", fires, 5);
      checkOutput("one_rsp_stall", bus.req_valid, 0);
      rsp_budget = 2;
      runSteps(5);
      checkOutput("two_rsp_fires", fires, 7);
      checkOutput("two_rsp_stall", bus.req_valid, 0);
      hold_rsp = 0;
      runLayer();

      $display("[TB] spurious response while idle");
      force_spur = 1;
      applyStimulus();
      applyStimulus();
      checkOutput("spur_err", err, 1);
      checkOutput("spur_no_write", bus.wr_en, 0);

      $display("[TB] reset mid-layer");
      pulseStart();
      runFires(101);
      checkOutput("err_sticky", err, 1);
      doReset();
      pulseStart();
      runLayer();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
